// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a shared FIFO. Tracks free FIFO slots as
// credits so a write is only granted when the FIFO is guaranteed to accept it.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic                             fifo_rd_ack,
    output logic [NUM_REQ-1:0]               gnt,
    output logic                             fifo_wr_en,
    output logic [DATA_WIDTH-1:0]            fifo_din,
    output logic [$clog2(DEPTH+1)-1:0]       credits,
    output logic                             err
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CRED_W = $clog2(DEPTH+1);
    localparam logic [CRED_W-1:0] FULL_CREDITS = CRED_W'(DEPTH);

    logic [IDX_W-1:0]      last;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    logic [NUM_REQ-1:0]    eligible;
    logic [DATA_WIDTH-1:0] win_data;
    logic [CRED_W-1:0]     credits_next;
    logic                  err_set;

    // A requester granted on the previous edge still shows req high while it
    // reacts to gnt, so it is masked out to avoid granting stale data twice.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        eligible  = (credits != '0) ? (req & ~gnt) : '0;
        win_found = 1'b0;
        win_idx   = last;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!win_found && eligible[(int'(last) + off) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(last) + off) % NUM_REQ);
            end
        end
    end

    assign win_data = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

    // A write and a read in the same cycle cancel; a read with the FIFO
    // already empty is a protocol violation and saturates instead of wrapping.
    always_comb begin
        credits_next = credits;
        err_set      = 1'b0;
        unique case ({win_found, fifo_rd_ack})
            2'b10: credits_next = credits - CRED_W'(1);
            2'b01: begin
                if (credits == FULL_CREDITS) begin
                    err_set = 1'b1;
                end else begin
                    credits_next = credits + CRED_W'(1);
                end
            end
            default: credits_next = credits;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt        <= '0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            credits    <= FULL_CREDITS;
            err        <= 1'b0;
            last       <= IDX_W'(NUM_REQ - 1);
        end else begin
            credits <= credits_next;
            if (err_set) begin
                err <= 1'b1;
            end
            if (win_found) begin
                gnt        <= NUM_REQ'(1) << win_idx;
                fifo_wr_en <= 1'b1;
                fifo_din   <= win_data;
                last       <= win_idx;
            end else begin
                gnt        <= '0;
                fifo_wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a directed vector table, corner-case
// sequences, and randomized traffic compared against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int CW      = $clog2(DEPTH+1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic                  ack;
    logic [NUM_REQ-1:0]    gnt;
    logic                  fifo_wr_en;
    logic [DW-1:0]         fifo_din;
    logic [CW-1:0]         credits;
    logic                  err;

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_rd_ack(ack),
        .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .credits(credits), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: free slots as a plain integer, grant as an index.
    int m_gnt_idx;   // -1 when no grant
    int m_credits;
    bit m_err;
    int m_last;
    int m_din;

    task automatic model_edge();
        int w;
        if (rst) begin
            m_gnt_idx = -1; m_din = 0; m_credits = DEPTH; m_err = 0; m_last = NUM_REQ-1;
        end else begin
            w = -1;
            if (m_credits > 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (m_last + k) % NUM_REQ;
                    if (w < 0 && req[c] && c != m_gnt_idx) w = c;
                end
            end
            m_credits = m_credits + (ack ? 1 : 0) - ((w >= 0) ? 1 : 0);
            if (m_credits > DEPTH) begin
                m_credits = DEPTH;
                m_err = 1;
            end
            m_gnt_idx = w;
            if (w >= 0) begin
                m_din  = int'(req_data[w*DW +: DW]);
                m_last = w;
            end
        end
    endtask

    function automatic logic [31:0] m_gnt_vec();
        return (m_gnt_idx < 0) ? 32'd0 : (32'd1 << m_gnt_idx);
    endfunction

    task automatic step(input bit cmp_model);
        @(posedge clk);
        model_edge();
        #1;
        if (cmp_model) begin
            check("model_gnt",     32'(gnt),        m_gnt_vec());
            check("model_wr_en",   32'(fifo_wr_en), (m_gnt_idx >= 0) ? 32'd1 : 32'd0);
            check("model_din",     32'(fifo_din),   32'(m_din));
            check("model_credits", 32'(credits),    32'(m_credits));
            check("model_err",     32'(err),        32'(m_err));
        end
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    typedef struct {
        bit                 rst;
        logic [NUM_REQ-1:0] req;
        bit                 ack;
        logic [NUM_REQ-1:0] gnt;
        bit                 wr;
        logic [DW-1:0]      din;
        int                 cred;
        bit                 err;
    } vec_t;

    vec_t vt[$];
    int   grant_cnt, b2b;
    logic prev_g2;

    initial begin
        rst = 1'b1; req = '0; ack = 1'b0; req_data = 32'h13121110;

        // Round-robin order, write/read cancellation and din hold.
        vt.push_back('{1, 4'h0, 0, 4'h0, 0, 8'h00, 16, 0});
        vt.push_back('{0, 4'hF, 0, 4'h1, 1, 8'h10, 15, 0});
        vt.push_back('{0, 4'hF, 0, 4'h2, 1, 8'h11, 14, 0});
        vt.push_back('{0, 4'hF, 0, 4'h4, 1, 8'h12, 13, 0});
        vt.push_back('{0, 4'hF, 0, 4'h8, 1, 8'h13, 12, 0});
        vt.push_back('{0, 4'hF, 0, 4'h1, 1, 8'h10, 11, 0});
        vt.push_back('{0, 4'hF, 1, 4'h2, 1, 8'h11, 11, 0});
        vt.push_back('{0, 4'h0, 1, 4'h0, 0, 8'h11, 12, 0});
        vt.push_back('{0, 4'h8, 0, 4'h8, 1, 8'h13, 11, 0});
        vt.push_back('{0, 4'h8, 0, 4'h0, 0, 8'h13, 11, 0});
        vt.push_back('{0, 4'h8, 0, 4'h8, 1, 8'h13, 10, 0});
        foreach (vt[i]) begin
            rst = vt[i].rst; req = vt[i].req; ack = vt[i].ack;
            step(0);
            check($sformatf("vec%0d_gnt", i),     32'(gnt),        32'(vt[i].gnt));
            check($sformatf("vec%0d_wr_en", i),   32'(fifo_wr_en), 32'(vt[i].wr));
            check($sformatf("vec%0d_din", i),     32'(fifo_din),   32'(vt[i].din));
            check($sformatf("vec%0d_credits", i), 32'(credits),    32'(vt[i].cred));
            check($sformatf("vec%0d_err", i),     32'(err),        32'(vt[i].err));
        end

        // Lone requester: every other cycle, stops after DEPTH writes.
        rst = 1'b1; req = '0; ack = 1'b0; step(1);
        rst = 1'b0; req = 4'b0100; set_data(2, 8'hA5);
        grant_cnt = 0; b2b = 0; prev_g2 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (gnt[2]) grant_cnt++;
            if (gnt[2] && prev_g2) b2b++;
            prev_g2 = gnt[2];
        end
        check("lone_grant_count", 32'(grant_cnt), 32'd16);
        check("lone_back_to_back", 32'(b2b), 32'd0);
        check("lone_credits_zero", 32'(credits), 32'd0);
        check("lone_gnt_idle", 32'(gnt), 32'd0);

        // Credits exhausted: one read frees one slot, grant one cycle later.
        req = 4'b0010; set_data(1, 8'h5C); ack = 1'b1;
        step(1);
        check("resume_credit_1", 32'(credits), 32'd1);
        check("resume_no_gnt_yet", 32'(gnt), 32'd0);
        ack = 1'b0;
        step(1);
        check("resume_gnt1", 32'(gnt), 32'h2);
        check("resume_din", 32'(fifo_din), 32'h5C);
        check("resume_credit_0", 32'(credits), 32'd0);
        req = '0;
        step(1);
        check("resume_gnt_drop", 32'(gnt), 32'd0);

        // Simultaneous write and read at credits=5.
        rst = 1'b1; step(1);
        rst = 1'b0; req = 4'hF; req_data = 32'h13121110;
        for (int c = 0; c < 11; c++) step(1);
        check("cancel_pre_credits", 32'(credits), 32'd5);
        ack = 1'b1;
        step(1);
        check("cancel_wr_en", 32'(fifo_wr_en), 32'd1);
        check("cancel_credits", 32'(credits), 32'd5);
        req = '0; ack = 1'b0; step(1);

        // Read on an empty FIFO: saturate and latch err.
        rst = 1'b1; step(1);
        rst = 1'b0; ack = 1'b1;
        step(1);
        check("spurious_credits", 32'(credits), 32'd16);
        check("spurious_err", 32'(err), 32'd1);
        ack = 1'b0;
        for (int c = 0; c < 3; c++) step(1);
        check("spurious_err_sticky", 32'(err), 32'd1);

        // Reset mid-burst at credits=9 with err set.
        req = 4'hF;
        for (int c = 0; c < 7; c++) step(1);
        check("midrst_pre_credits", 32'(credits), 32'd9);
        rst = 1'b1;
        step(1);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("midrst_credits", 32'(credits), 32'd16);
        check("midrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step(1);
        check("midrst_first_gnt", 32'(gnt), 32'h1);

        // Randomized traffic honouring the requester handshake.
        rst = 1'b1; req = '0; ack = 1'b0; step(1);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && m_gnt_idx == i) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else set_data(i, DW'($urandom));
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_data(i, DW'($urandom));
                end
            end
            if (m_credits < DEPTH) ack = ($urandom_range(0, 2) == 0);
            else ack = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
